// File: rtl/hpdmc_mgmt_arb_pkg.sv
`default_nettype none
// ============================================================================
//  hpdmc_mgmt_arb_pkg
//  Shared state encoding and address-width helper for the HPDMC management
//  command-port arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package hpdmc_mgmt_arb_pkg;

    // Arbiter is either idle or has granted the port to one master.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // 32-bit word address width derived from the SDRAM byte-address depth.
    function automatic int calc_aw(input int depth);
        return depth - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hpdmc_rr_pick.sv
`default_nettype none
// ============================================================================
//  hpdmc_rr_pick
//  Combinational round-robin picker: first set bit of mask scanning upward
//  from start, wrapping modulo NREQ. found=0 when mask is empty.
//  Revision: 1.0  initial release
// ============================================================================
module hpdmc_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] mask,
    input  logic [IDW-1:0]  start,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    // Scan from the farthest candidate back to start so the nearest one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (mask[(int'(start) + k) % NREQ]) begin
                found = 1'b1;
                idx   = IDW'((int'(start) + k) % NREQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hpdmc_mgmt_arb.sv
`default_nettype none
// ============================================================================
//  hpdmc_mgmt_arb
//  Round-robin arbiter sharing the HPDMC management command port between
//  NREQ masters. A grant is held for up to MAX_HOLD acked commands so page-hit
//  streaks stay together; handoffs are registered.
//  Revision: 1.0  initial release
// ============================================================================
module hpdmc_mgmt_arb
    import hpdmc_mgmt_arb_pkg::*;
#(
    parameter int sdram_depth = 26,
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int MAX_HOLD    = 8
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst_n,
    input  logic [NREQ-1:0]                  req_stb,
    input  logic [NREQ-1:0]                  req_we,
    input  logic [NREQ*calc_aw(sdram_depth)-1:0] req_address,
    output logic [NREQ-1:0]                  req_ack,
    output logic                             mgmt_stb,
    output logic                             mgmt_we,
    output logic [calc_aw(sdram_depth)-1:0]  mgmt_address,
    input  logic                             mgmt_ack,
    output logic [IDW-1:0]                   owner_id,
    output logic                             owner_valid
);

    localparam int AW = calc_aw(sdram_depth);
    localparam logic [3:0]     HOLD_LAST = 4'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

    arb_state_t     state, state_n;
    logic [IDW-1:0] owner, owner_n;
    logic [IDW-1:0] last,  last_n;
    logic [3:0]     hold_cnt, hold_n;

    logic [IDW-1:0] idle_start, rel_start;
    logic           idle_found, rel_found;
    logic [IDW-1:0] idle_idx,   rel_idx;
    logic [NREQ-1:0] rel_mask;
    logic           owner_stb;
    logic           ack_ok;

    // Start points wrap NREQ-1 -> 0 even when NREQ is not a power of two.
    always_comb begin
        idle_start = (last  == ID_LAST) ? '0 : last  + 1'b1;
        rel_start  = (owner == ID_LAST) ? '0 : owner + 1'b1;
        rel_mask   = req_stb & ~(NREQ'(1) << owner);
    end

    hpdmc_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_idle (
        .mask  (req_stb),
        .start (idle_start),
        .found (idle_found),
        .idx   (idle_idx)
    );

    hpdmc_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick_rel (
        .mask  (rel_mask),
        .start (rel_start),
        .found (rel_found),
        .idx   (rel_idx)
    );

    // Owner's request as seen by the port; an ack only counts while it is up.
    always_comb begin
        owner_stb = req_stb[owner];
        ack_ok    = mgmt_ack & owner_stb;
    end

    // State, owner, round-robin pointer and hold counter registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            last     <= ID_LAST;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
        end
    end

    // Grant / release decisions; withdrawal outranks hold-limit expiry.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            ARB_IDLE: begin
                if (idle_found) begin
                    owner_n = idle_idx;
                    hold_n  = '0;
                    state_n = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!owner_stb) begin
                    last_n = owner;
                    hold_n = '0;
                    if (rel_found) begin
                        owner_n = rel_idx;
                    end else begin
                        state_n = ARB_IDLE;
                    end
                end else if (ack_ok) begin
                    if (hold_cnt == HOLD_LAST) begin
                        last_n = owner;
                        hold_n = '0;
                        if (rel_found) begin
                            owner_n = rel_idx;
                        end
                    end else begin
                        hold_n = hold_cnt + 4'd1;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Output mux from the owner and ack demux back to it; all zero when idle.
    always_comb begin
        owner_valid  = (state == ARB_OWN);
        owner_id     = owner_valid ? owner : '0;
        mgmt_stb     = owner_valid & owner_stb;
        mgmt_we      = owner_valid & req_we[owner];
        mgmt_address = owner_valid ? req_address[int'(owner)*AW +: AW] : '0;
        req_ack      = '0;
        req_ack[owner] = owner_valid & ack_ok;
    end

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_mgmt_arb.sv
`default_nettype none
// ============================================================================
//  tb_hpdmc_mgmt_arb
//  Self-checking bench: directed vector table, hand-written streaming and
//  reset sequences, and randomized masters against a reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_hpdmc_mgmt_arb;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int AW       = 24;
    localparam int MAX_HOLD = 8;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [NREQ-1:0] req_stb;
    logic [NREQ-1:0] req_we;
    logic [NREQ*AW-1:0] req_address;
    logic [NREQ-1:0] req_ack;
    logic            mgmt_stb;
    logic            mgmt_we;
    logic [AW-1:0]   mgmt_address;
    logic            mgmt_ack;
    logic [IDW-1:0]  owner_id;
    logic            owner_valid;

    logic [AW-1:0] addr_v [NREQ];

    int n_cmp = 0;
    int n_bad = 0;

    assign req_address = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

    hpdmc_mgmt_arb #(
        .sdram_depth (26),
        .NREQ        (NREQ),
        .IDW         (IDW),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_stb      (req_stb),
        .req_we       (req_we),
        .req_address  (req_address),
        .req_ack      (req_ack),
        .mgmt_stb     (mgmt_stb),
        .mgmt_we      (mgmt_we),
        .mgmt_address (mgmt_address),
        .mgmt_ack     (mgmt_ack),
        .owner_id     (owner_id),
        .owner_valid  (owner_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] stb;
        logic [3:0] we;
        logic       ack;
        logic       e_stb;
        logic       e_we;
        logic       e_valid;
        logic [1:0] e_id;
        logic [3:0] e_rack;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_stb   = '0;
        req_we    = '0;
        mgmt_ack  = 1'b0;
        next_cycle();
        next_cycle();
        sys_rst_n = 1'b1;
    endtask

    // Round-robin choice straight from the rule: first requester at or after start.
    function automatic int rr(input logic [3:0] m, input int s);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(s + k) % NREQ]) return (s + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model state
    bit m_valid;
    int m_owner, m_last, m_hold;

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_last  = NREQ - 1;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] stb, input logic ack);
        logic [3:0] others;
        int w;
        others = stb;
        others[m_owner] = 1'b0;
        if (!m_valid) begin
            if (stb != 0) begin
                m_owner = rr(stb, (m_last + 1) % NREQ);
                m_hold  = 0;
                m_valid = 1'b1;
            end
        end else if (!stb[m_owner]) begin
            m_last = m_owner;
            m_hold = 0;
            w = rr(others, (m_owner + 1) % NREQ);
            if (w < 0) m_valid = 1'b0;
            else       m_owner = w;
        end else if (ack) begin
            if (m_hold == MAX_HOLD - 1) begin
                m_last = m_owner;
                m_hold = 0;
                w = rr(others, (m_owner + 1) % NREQ);
                if (w >= 0) m_owner = w;
            end else begin
                m_hold++;
            end
        end
    endtask

    initial begin
        bit         pend [NREQ];
        logic [3:0] e_rack;
        logic [3:0] s;
        int         r;

        for (int i = 0; i < NREQ; i++) addr_v[i] = 24'h0A0000 + 24'(i * 24'h1111);
        sys_rst_n = 1'b0;
        req_stb   = 4'b1111;
        req_we    = 4'b1111;
        mgmt_ack  = 1'b0;

        // ---- Reset with every master requesting ----
        next_cycle();
        next_cycle();
        @(negedge sys_clk);
        chk("rst_mgmt_stb", 64'(mgmt_stb), 64'd0);
        chk("rst_mgmt_we", 64'(mgmt_we), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_valid", 64'(owner_valid), 64'd0);
        chk("rst_id", 64'(owner_id), 64'd0);
        chk("rst_ack", 64'(req_ack), 64'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        next_cycle();
        @(negedge sys_clk);
        chk("rel_valid", 64'(owner_valid), 64'd1);
        chk("rel_id", 64'(owner_id), 64'd0);
        chk("rel_stb", 64'(mgmt_stb), 64'd1);

        // ---- Async reset while an ack is on the port ----
        @(posedge sys_clk);
        #1;
        mgmt_ack = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_ack", 64'(req_ack), 64'd0);
        chk("arst_valid", 64'(owner_valid), 64'd0);
        chk("arst_stb", 64'(mgmt_stb), 64'd0);
        do_reset();

        // ---- Directed vector table: single master reads, then withdrawal ----
        tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[3]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0000};
        tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[9]  = '{4'b0110, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b0110, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[11] = '{4'b0100, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[12] = '{4'b0100, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0100};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        for (int v = 0; v < 15; v++) begin
            req_stb  = tbl[v].stb;
            req_we   = tbl[v].we;
            mgmt_ack = tbl[v].ack;
            @(negedge sys_clk);
            chk($sformatf("tbl%0d_stb", v), 64'(mgmt_stb), 64'(tbl[v].e_stb));
            chk($sformatf("tbl%0d_we", v), 64'(mgmt_we), 64'(tbl[v].e_we));
            chk($sformatf("tbl%0d_valid", v), 64'(owner_valid), 64'(tbl[v].e_valid));
            chk($sformatf("tbl%0d_id", v), 64'(owner_id), 64'(tbl[v].e_id));
            chk($sformatf("tbl%0d_ack", v), 64'(req_ack), 64'(tbl[v].e_rack));
            chk($sformatf("tbl%0d_addr", v), 64'(mgmt_address),
                tbl[v].e_valid ? 64'(addr_v[tbl[v].e_id]) : 64'd0);
            next_cycle();
        end

        // ---- Masters 0 and 1 streaming, ack every cycle: 8/8/8 rotation ----
        do_reset();
        req_stb  = 4'b0011;
        mgmt_ack = 1'b1;
        @(negedge sys_clk);
        chk("strm_idle_ack", 64'(req_ack), 64'd0);
        next_cycle();
        for (int k = 0; k < 24; k++) begin
            r = ((k / MAX_HOLD) % 2 == 0) ? 0 : 1;
            @(negedge sys_clk);
            chk($sformatf("strm%0d_ack", k), 64'(req_ack), 64'(1 << r));
            chk($sformatf("strm%0d_stb", k), 64'(mgmt_stb), 64'd1);
            chk($sformatf("strm%0d_addr", k), 64'(mgmt_address), 64'(addr_v[r]));
            next_cycle();
        end

        // ---- Lone master 3, 20 acks: grant kept, hold counter wraps ----
        do_reset();
        req_stb  = 4'b1000;
        mgmt_ack = 1'b1;
        next_cycle();
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            chk($sformatf("solo%0d_ack", k), 64'(req_ack), 64'b1000);
            chk($sformatf("solo%0d_id", k), 64'(owner_id), 64'd3);
            chk($sformatf("solo%0d_hold", k), 64'(dut.hold_cnt), 64'(k % MAX_HOLD));
            next_cycle();
        end

        // ---- Randomized masters against the reference model ----
        do_reset();
        model_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) req_stb[i] = pend[i];
            mgmt_ack = ($urandom_range(0, 2) != 0);
            s = req_stb;
            e_rack = '0;
            if (m_valid && s[m_owner] && mgmt_ack) e_rack[m_owner] = 1'b1;
            @(negedge sys_clk);
            chk("rnd_valid", 64'(owner_valid), 64'(m_valid));
            chk("rnd_id", 64'(owner_id), m_valid ? 64'(m_owner) : 64'd0);
            chk("rnd_stb", 64'(mgmt_stb), 64'(m_valid && s[m_owner]));
            chk("rnd_we", 64'(mgmt_we), 64'(m_valid && req_we[m_owner]));
            chk("rnd_addr", 64'(mgmt_address), m_valid ? 64'(addr_v[m_owner]) : 64'd0);
            chk("rnd_ack", 64'(req_ack), 64'(e_rack));
            model_step(s, mgmt_ack);
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (e_rack[i] || (!pend[i] && $urandom_range(0, 2) == 0)) begin
                    pend[i]   = e_rack[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_we[i] = 1'($urandom);
                    addr_v[i] = 24'($urandom);
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
